// File: rtl/counter_sched_pkg.sv
// Shared types and default sizes for the counter_sched timer scheduler.
package counter_sched_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} sched_state_t;

  localparam int CNT_W_DEF = 8;
  localparam int N_REQ_DEF = 4;

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N_REQ);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  // One extra bit on the sum lets the modulo work for non-power-of-two N_REQ.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    sum   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (sum >= N_L) sum = sum - N_L;
      cand = sum[IDX_W-1:0];
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/counter_sched.sv
// One shared down-counting tick timer, time-shared round-robin between N_REQ requesters.
// Optional abort support is compiled in with `define COUNTER_SCHED_ABORT_EN.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ*CNT_W-1:0] ticks_i,
`ifdef COUNTER_SCHED_ABORT_EN
  input  logic               abort_i,
  output logic [N_REQ-1:0]   aborted_o,
`endif
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               tick_o,
  output logic [N_REQ-1:0]   done_o
);

  localparam int IDX_W = $clog2(N_REQ);

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, win_q, win_d, next_ptr;
  logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] ticks_arr [N_REQ];
  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
`ifdef COUNTER_SCHED_ABORT_EN
  logic [N_REQ-1:0] aborted_q, aborted_d;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ticks
      assign ticks_arr[gi] = ticks_i[gi*CNT_W +: CNT_W];
    end
  endgenerate

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign next_ptr = (win_q == IDX_W'(N_REQ-1)) ? '0 : win_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = grant_q;
    count_d = count_q;
    tick_d  = 1'b0;
    done_d  = '0;
`ifdef COUNTER_SCHED_ABORT_EN
    aborted_d = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = LOAD;
          win_d   = arb_idx;
          grant_d = arb_gnt;
        end
      end
      LOAD: begin
        count_d = ticks_arr[win_q];
        if (ticks_arr[win_q] == '0) begin
          state_d = DONE;
          done_d  = grant_q;
        end else begin
          state_d = COUNT;
          tick_d  = 1'b1;
        end
      end
      COUNT: begin
        // Guarded decrement: the counter saturates at zero rather than wrapping.
        if (count_q != '0) count_d = count_q - CNT_W'(1);
        if (count_q <= CNT_W'(1)) begin
          state_d = DONE;
          done_d  = grant_q;
        end else begin
          tick_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = next_ptr;
      end
      default: state_d = IDLE;
    endcase
`ifdef COUNTER_SCHED_ABORT_EN
    if (abort_i && (state_q == LOAD || state_q == COUNT)) begin
      state_d   = IDLE;
      grant_d   = '0;
      count_d   = '0;
      tick_d    = 1'b0;
      done_d    = '0;
      aborted_d = grant_q;
      ptr_d     = next_ptr;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      done_q  <= '0;
`ifdef COUNTER_SCHED_ABORT_EN
      aborted_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
`ifdef COUNTER_SCHED_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);
  assign count_o = count_q;
  assign tick_o  = tick_q;
  assign done_o  = done_q;
`ifdef COUNTER_SCHED_ABORT_EN
  assign aborted_o = aborted_q;
`endif

endmodule
